seg_scan_mux: RTL and testbench

//  Time-multiplexed scan driver for the 4-digit 7-segment display. Holds four BCD digits in a

---
 rtl/seg_scan_mux_pkg.sv | 30 +++
 rtl/seg_scan_mux_if.sv | 41 ++++
 rtl/seg_scan_mux_refresh_tick_gen.sv | 43 ++++
 rtl/seg_scan_mux.sv | 127 ++++++++++++
 tb/tb_seg_scan_mux.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux_pkg
// Description : Shared constants, types and helpers for the 4-digit
//               7-segment scan driver (digit count, anode-off pattern,
//               digit slicing and leading-zero test).
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_mux_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    typedef logic [1:0]  digit_idx_t;
    typedef logic [3:0]  bcd_t;
    typedef logic [15:0] frame_t;

    // Extract BCD digit 'idx' from a packed four-digit frame (digit0 = LSBs).
    function automatic bcd_t digit_slice(input frame_t frame, input digit_idx_t idx);
        return frame[{idx, 2'b00} +: 4];
    endfunction

    // True when digit 'idx' and every more-significant digit are zero,
    // i.e. digit 'idx' is a leading zero.
    function automatic logic upper_digits_zero(input frame_t frame, input digit_idx_t idx);
        return (frame >> {idx, 2'b00}) == 16'h0000;
    endfunction

endpackage : seg_scan_mux_pkg
`default_nettype wire

// File: rtl/seg_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux_if
// Description : Signal bundle between the frame source / display side and
//               the scan driver.
//   DATA     [15:0] four BCD digits, [15:12] = MSD
//   LOAD            one-cycle capture strobe for DATA
//   DIGIT_EN [3:0]  per-digit enables (0 = dark)
//   BLANK_LZ        blank leading zeros
//   BCD_OUT  [3:0]  BCD code to the decoder
//   SELECT          decoder select (0 = blank pattern)
//   AN       [3:0]  active-low anodes
//   FRAME           one-cycle pulse at the start of each frame
//   master: drives the inputs and observes the display outputs
//   slave : the scan driver
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_mux_if;
    import seg_scan_mux_pkg::*;

    frame_t      DATA;
    logic        LOAD;
    logic [3:0]  DIGIT_EN;
    logic        BLANK_LZ;
    bcd_t        BCD_OUT;
    logic        SELECT;
    logic [3:0]  AN;
    logic        FRAME;

    modport master (
        output DATA, LOAD, DIGIT_EN, BLANK_LZ,
        input  BCD_OUT, SELECT, AN, FRAME
    );

    modport slave (
        input  DATA, LOAD, DIGIT_EN, BLANK_LZ,
        output BCD_OUT, SELECT, AN, FRAME
    );

endinterface : seg_scan_mux_if
`default_nettype wire

// File: rtl/seg_scan_mux_refresh_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : refresh_tick_gen
// Description : Free-running slot counter 0..DIV-1 with a terminal-count
//               tick asserted while the count equals DIV-1.
//   clk, reset : clock, synchronous active-high reset
//   count      : current count within the slot
//   tick       : high on the last clock of each slot
// Revision    : 1.0 - initial release
// ============================================================================
module refresh_tick_gen #(
    parameter int DIV   = 50000,
    parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    output logic [CNT_W-1:0]      count,
    output logic                  tick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick  = (count_q == CNT_W'(DIV - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q + 1'b1;
        if (tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : refresh_tick_gen
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux
// Description : Time-multiplexed scan driver for a 4-digit 7-segment display.
//               Double-buffers four BCD digits, steps one digit per refresh
//               slot and drives a single shared BCD decoder plus the
//               active-low anodes.
//   clk, reset : clock, synchronous active-high reset
//   bus        : seg_scan_mux_if slave (DATA/LOAD/DIGIT_EN/BLANK_LZ in,
//                BCD_OUT/SELECT/AN/FRAME out)
//   REFRESH_DIV: clocks per digit slot (>= 4)
//   GUARD      : anode-off clocks at slot start (< REFRESH_DIV)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seg_scan_mux_if.slave      bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] w_count;
    logic             w_tick;

    refresh_tick_gen #(
        .DIV   (REFRESH_DIV),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .count (w_count),
        .tick  (w_tick)
    );

    digit_idx_t index_q,   index_d;
    frame_t     pending_q, pending_d;
    frame_t     front_q,   front_d;
    logic       pflag_q,   pflag_d;
    bcd_t       bcd_out_q, bcd_out_d;
    logic       select_q,  select_d;
    logic [3:0] an_q,      an_d;
    logic       frame_q,   frame_d;

    logic       w_wrap;
    logic       w_blank;

    // Frame boundary: last clock of digit3's slot.
    assign w_wrap = w_tick && (index_q == digit_idx_t'(NUM_DIGITS - 1));

    // Index and double-buffer control.
    always_comb begin
        index_d   = index_q;
        pending_d = pending_q;
        front_d   = front_q;
        pflag_d   = pflag_q;

        if (w_tick) begin
            index_d = index_q + 2'd1;
        end

        if (bus.LOAD) begin
            pending_d = bus.DATA;
        end

        if (w_wrap) begin
            // A LOAD on the boundary clock bypasses the pending buffer so the
            // new value is shown in the frame that starts now.
            if (bus.LOAD) begin
                front_d = bus.DATA;
            end else if (pflag_q) begin
                front_d = pending_q;
            end
            pflag_d = 1'b0;
        end else if (bus.LOAD) begin
            pflag_d = 1'b1;
        end
    end

    // Blanking and registered display outputs for the current digit.
    always_comb begin
        w_blank = !bus.DIGIT_EN[index_q] ||
                  (bus.BLANK_LZ && (index_q != 2'd0) && upper_digits_zero(front_q, index_q));

        bcd_out_d = digit_slice(front_q, index_q);
        select_d  = !w_blank;
        an_d      = AN_OFF;
        if (!w_blank && (w_count >= CNT_W'(GUARD))) begin
            an_d = ~(4'b0001 << index_q);
        end
        frame_d   = w_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q   <= '0;
            pending_q <= '0;
            front_q   <= '0;
            pflag_q   <= 1'b0;
            bcd_out_q <= '0;
            select_q  <= 1'b0;
            an_q      <= AN_OFF;
            frame_q   <= 1'b0;
        end else begin
            index_q   <= index_d;
            pending_q <= pending_d;
            front_q   <= front_d;
            pflag_q   <= pflag_d;
            bcd_out_q <= bcd_out_d;
            select_q  <= select_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.BCD_OUT = bcd_out_q;
    assign bus.SELECT  = select_q;
    assign bus.AN      = an_q;
    assign bus.FRAME   = frame_q;

endmodule : seg_scan_mux
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_mux
// Description : Scoreboard bench for seg_scan_mux (REFRESH_DIV=4, GUARD=1).
//               A timeline reference model predicts each clock's display
//               outputs; a monitor compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

    localparam int TB_DIV   = 4;
    localparam int TB_GUARD = 1;
    localparam int FRAME_CLKS = 4 * TB_DIV;
    localparam int TIMEOUT_NS = 1000000;

    typedef struct packed {
        logic [3:0] bcd;
        logic       sel;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    logic clk;
    logic reset;

    seg_scan_mux_if sif ();

    seg_scan_mux #(
        .REFRESH_DIV (TB_DIV),
        .GUARD       (TB_GUARD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus state
    logic        rst_v;
    logic [15:0] data_v;
    logic        load_v;
    logic [3:0]  en_v;
    logic        blz_v;

    // Reference model: k clocks since reset, latest loaded value, and the
    // value latched for the frame currently on display.
    int          k;
    logic [15:0] latest_m;
    logic [15:0] front_m;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    // Expected outputs after the coming clock edge, from the state before it.
    function automatic exp_t predict();
        exp_t e;
        int   idx;
        int   pos;
        logic blank;
        if (rst_v) begin
            e.bcd = 4'h0; e.sel = 1'b0; e.an = 4'hF; e.frame = 1'b0;
            return e;
        end
        idx   = (k / TB_DIV) % 4;
        pos   = k % TB_DIV;
        blank = !en_v[idx] || (blz_v && idx > 0 && ((front_m >> (4 * idx)) == 16'h0));
        e.bcd   = 4'((front_m >> (4 * idx)) & 16'hF);
        e.sel   = !blank;
        e.an    = (!blank && pos >= TB_GUARD) ? ~(4'b0001 << idx) : 4'hF;
        e.frame = ((k % FRAME_CLKS) == FRAME_CLKS - 1);
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        reset        = rst_v;
        sif.DATA     = data_v;
        sif.LOAD     = load_v;
        sif.DIGIT_EN = en_v;
        sif.BLANK_LZ = blz_v;
        exp_q.push_back(predict());
        if (rst_v) begin
            k = 0; latest_m = 16'h0; front_m = 16'h0;
        end else begin
            if (load_v) latest_m = data_v;
            if ((k % FRAME_CLKS) == FRAME_CLKS - 1) front_m = latest_m;
            k = k + 1;
        end
        load_v = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [15:0] d);
        data_v = d;
        load_v = 1'b1;
        step();
    endtask

    // Advance until the model's position within the frame equals 'target'.
    task automatic align(input int target);
        for (int i = 0; i < FRAME_CLKS && (k % FRAME_CLKS) != target; i++) step();
        checks++;
        if ((k % FRAME_CLKS) != target) begin
            errors++;
            $display("FAIL align t=%0t wait for frame position %0d expired at %0d",
                     $time, target, k % FRAME_CLKS);
        end
    endtask

    // Directly check the reset state of the outputs after the reset edge.
    task automatic check_reset_state(input string tag);
        @(posedge clk);
        #1;
        checks++;
        if (sif.AN !== 4'hF || sif.SELECT !== 1'b0 || sif.BCD_OUT !== 4'h0 || sif.FRAME !== 1'b0) begin
            errors++;
            $display("FAIL reset_state %s t=%0t an=%b sel=%b bcd=%h frame=%b",
                     tag, $time, sif.AN, sif.SELECT, sif.BCD_OUT, sif.FRAME);
        end
    endtask

    // Monitor: the DUT presents a full output set every clock.
    initial begin
        exp_t e;
        exp_t got;
        checks = 0;
        errors = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got.bcd = sif.BCD_OUT; got.sel = sif.SELECT;
                got.an  = sif.AN;      got.frame = sif.FRAME;
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL scan_out t=%0t got bcd=%h sel=%b an=%b frame=%b exp bcd=%h sel=%b an=%b frame=%b",
                             $time, got.bcd, got.sel, got.an, got.frame,
                             e.bcd, e.sel, e.an, e.frame);
                end
            end
        end
    end

    // Watchdog: the run must finish within the time budget.
    initial begin
        #(TIMEOUT_NS);
        errors++;
        $display("FAIL timeout: simulation did not finish within %0d ns", TIMEOUT_NS);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        k = 0; latest_m = 16'h0; front_m = 16'h0;
        rst_v = 1'b1; data_v = 16'h0; load_v = 1'b0; en_v = 4'hF; blz_v = 1'b0;
        reset = 1'b1;
        sif.DATA = 16'h0; sif.LOAD = 1'b0; sif.DIGIT_EN = 4'hF; sif.BLANK_LZ = 1'b0;

        run(3);
        check_reset_state("initial");
        rst_v = 1'b0;

        // Basic scan of 1234
        load(16'h1234);
        run(40);

        // Leading-zero blanking
        blz_v = 1'b1;
        load(16'h0070);
        run(40);

        // All zeros: only digit0 lit, then digit0 disabled too
        load(16'h0000);
        run(36);
        en_v = 4'b1110;
        run(36);
        en_v = 4'hF;
        blz_v = 1'b0;

        // Mid-frame load at index 1 must not tear the current frame
        load(16'h1234);
        run(36);
        align(TB_DIV);
        load(16'h5555);
        run(36);

        // Load on the wrap clock is visible in the new frame
        align(FRAME_CLKS - 1);
        load(16'h9876);
        run(20);

        // Reset while index 2 is active
        align(2 * TB_DIV);
        rst_v = 1'b1;
        step();
        check_reset_state("mid_frame");
        rst_v = 1'b0;
        run(50);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ((i % 37) == 0) begin
                en_v  = 4'($urandom_range(0, 15));
                blz_v = 1'($urandom_range(0, 1));
            end
            rst_v = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) begin
                data_v = 16'($urandom);
                load_v = 1'b1;
            end
            step();
        end
        rst_v = 1'b0;
        run(2);

        @(posedge clk);
        #2;
        if (errors == 0) begin
            $display("PASS: %0d checks", checks);
        end else begin
            $display("FAIL: %0d errors in %0d checks", errors, checks);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seg_scan_mux
`default_nettype wire
